timer_ctrl_master: RTL and testbench

- Avalon-MM master that drives the per-processor interval-timer slave: 16-bit data, 3-bit word address, registered readdata with 1-cycle read latency, no waitrequest.
- Turns simple command requests into the timer register access sequences: configure/start, stop and snapshot.
- Services the timer IRQ in hardware by clearing status and counting ticks, so processing cores can read tick time without ISR overhead.
- Sits between the processing control logic and the timer slave inside the processor subsystem.

---
 rtl/timer_ctrl_master.sv | 159 +++++++++++++++
 tb/tb_timer_ctrl_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master for the interval-timer slave: sequences configure/start, stop and
// snapshot register accesses, and services the timer IRQ in hardware by counting ticks.
module timer_ctrl_master #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h00022E97,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TICK_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [TICK_W-1:0] tick_count,
  output logic              tick,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, CFG_PL, CFG_PH, CFG_CTL, STOP_CTL,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP, CLR
  } state_e;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_SNAP  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'h0000};

  state_e      state, next_state;
  bus_t        bus_q, bus_d;
  logic        armed;
  logic [31:0] period_q, period_nxt;
  logic        cont_q, cont_nxt;
  logic [15:0] snap_lo;
  logic        accept;

  // Bus cycle driven while the FSM sits in a given state.
  function automatic bus_t bus_of(state_e s, logic [31:0] period, logic cont);
    bus_t b;
    b = BUS_IDLE;
    case (s)
      CFG_PL:   b = '{1'b1, 1'b0, 3'd2, period[15:0]};
      CFG_PH:   b = '{1'b1, 1'b0, 3'd3, period[31:16]};
      CFG_CTL:  b = '{1'b1, 1'b0, 3'd1, {13'd0, 1'b1, cont, 1'b1}};
      STOP_CTL: b = '{1'b1, 1'b0, 3'd1, 16'h0008};
      SNAP_W:   b = '{1'b1, 1'b0, 3'd4, 16'h0000};
      SNAP_RL:  b = '{1'b1, 1'b1, 3'd4, 16'h0000};
      SNAP_RH:  b = '{1'b1, 1'b1, 3'd5, 16'h0000};
      CLR:      b = '{1'b1, 1'b0, 3'd0, 16'h0000};
      default:  b = BUS_IDLE;
    endcase
    return b;
  endfunction

  // armed is low for the first cycle after reset so the registered bus can catch up
  // with the reset state before the FSM leaves it.
  assign cmd_ready = (state == IDLE) && armed && !tmr_irq;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    next_state = state;
    period_nxt = period_q;
    cont_nxt   = cont_q;
    case (state)
      IDLE: begin
        if (armed && tmr_irq) begin
          next_state = CLR;
        end else if (accept) begin
          case (op_e'(cmd_op))
            OP_START: begin
              next_state = CFG_PL;
              period_nxt = cmd_period;
              cont_nxt   = cmd_continuous;
            end
            OP_STOP: next_state = STOP_CTL;
            OP_SNAP: next_state = SNAP_W;
            default: next_state = IDLE;
          endcase
        end
      end
      CFG_PL:   if (armed) next_state = CFG_PH;
      CFG_PH:   next_state = CFG_CTL;
      CFG_CTL:  next_state = IDLE;
      STOP_CTL: next_state = IDLE;
      SNAP_W:   next_state = SNAP_RL;
      SNAP_RL:  next_state = SNAP_RH;
      SNAP_RH:  next_state = SNAP_CAP;
      SNAP_CAP: next_state = IDLE;
      CLR:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The bus register is loaded from the state being entered, so the registered bus
  // lines up with the state register in the same cycle.
  assign bus_d = bus_of(next_state, period_nxt, cont_nxt);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state      <= AUTO_START ? CFG_PL : IDLE;
      armed      <= 1'b0;
      bus_q      <= BUS_IDLE;
      busy       <= 1'b0;
      period_q   <= DEFAULT_PERIOD;
      cont_q     <= 1'b1;
      snap_lo    <= 16'h0000;
      snap_value <= 32'h0;
      snap_valid <= 1'b0;
      tick_count <= '0;
      tick       <= 1'b0;
    end else begin
      armed      <= 1'b1;
      state      <= next_state;
      bus_q      <= bus_d;
      busy       <= (next_state != IDLE);
      period_q   <= period_nxt;
      cont_q     <= cont_nxt;
      snap_valid <= 1'b0;
      tick       <= 1'b0;
      if (state == SNAP_RH) snap_lo <= tmr_readdata;
      if (state == SNAP_CAP) begin
        snap_value <= {tmr_readdata, snap_lo};
        snap_valid <= 1'b1;
      end
      if (state == CLR) begin
        tick_count <= tick_count + TICK_W'(1);
        tick       <= 1'b1;
      end
    end
  end

  assign tmr_chipselect = bus_q.cs;
  assign tmr_write_n    = bus_q.write_n;
  assign tmr_address    = bus_q.addr;
  assign tmr_writedata  = bus_q.data;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Self-checking bench for timer_ctrl_master: timer slave model plus a queue of
// expected bus transactions compared as the master issues them.
module tb_timer_ctrl_master;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [31:0]   cmd_period = 32'h0;
  logic          cmd_continuous = 1'b0;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect;
  logic          tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata = 16'h0;
  logic          tmr_irq = 1'b0;
  logic [31:0]   snap_value;
  logic          snap_valid;
  logic [TW-1:0] tick_count;
  logic          tick;
  logic          busy;
  logic          irq_raise = 1'b0;

  timer_ctrl_master #(.DEFAULT_PERIOD(32'h00022E97), .AUTO_START(1'b1), .TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .snap_value(snap_value), .snap_valid(snap_valid),
    .tick_count(tick_count), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timer slave: registered readdata, irq level cleared by a status write.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                      (tmr_address == 3'd5) ? 16'h0001 : 16'h0000;
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
    else if (irq_raise) tmr_irq <= 1'b1;
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          snap_pulses = 0;
  int          snap_cyc = 0;
  int          tick_pulses = 0;
  int          exp_ticks = 0;
  int          acc = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [2:0] a);
    exp_q.push_back({1'b0, a, 16'h0000});
  endtask

  // One clock, then sample and score the bus away from the edge.
  task automatic step();
    logic [19:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (tmr_chipselect) begin
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("bus_tx", {12'h0, ~tmr_write_n, tmr_address, tmr_writedata}, {12'h0, e});
      end
    end else begin
      check("bus_idle", {12'h0, tmr_write_n, tmr_address, tmr_writedata}, {12'h0, 1'b1, 19'h0});
    end
    if (snap_valid) begin
      snap_pulses++;
      snap_cyc = cyc;
    end
    if (tick) tick_pulses++;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                          output int acc_cyc);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_period = per;
    cmd_continuous = cont;
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic service_irq();
    push_wr(3'd0, 16'h0000);
    exp_ticks++;
    irq_raise = 1'b1;
    step();
    irq_raise = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    check("rst_snap_value", snap_value, 32'h0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);

    // Automatic start after reset release
    push_wr(3'd2, 16'h2E97);
    push_wr(3'd3, 16'h0002);
    push_wr(3'd1, 16'h0007);
    reset_n = 1'b1;
    repeat (4) step();
    check("auto_busy", 32'(busy), 32'd0);
    check("auto_cmd_ready", 32'(cmd_ready), 32'd1);
    check("auto_q_empty", 32'(exp_q.size()), 32'd0);

    // One-shot START then STOP
    push_wr(3'd2, 16'h0010);
    push_wr(3'd3, 16'h0000);
    push_wr(3'd1, 16'h0005);
    send_cmd(2'd0, 32'h0000_0010, 1'b0, acc);
    wait_idle();
    check("start_q_empty", 32'(exp_q.size()), 32'd0);
    push_wr(3'd1, 16'h0008);
    send_cmd(2'd1, 32'h0, 1'b0, acc);
    wait_idle();
    check("stop_q_empty", 32'(exp_q.size()), 32'd0);

    // Snapshot
    push_wr(3'd4, 16'h0000);
    push_rd(3'd4);
    push_rd(3'd5);
    send_cmd(2'd2, 32'h0, 1'b0, acc);
    wait_idle();
    repeat (2) step();
    check("snap_value", snap_value, 32'h0001_1234);
    check("snap_pulses", 32'(snap_pulses), 32'd1);
    check("snap_latency", 32'(snap_cyc - acc), 32'd5);
    check("snap_q_empty", 32'(exp_q.size()), 32'd0);

    // IRQ service: one status write, one tick
    push_wr(3'd0, 16'h0000);
    exp_ticks++;
    irq_raise = 1'b1;
    step();
    irq_raise = 1'b0;
    check("irq_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    check("clr_busy", 32'(busy), 32'd1);
    wait_idle();
    repeat (2) step();
    check("irq_tick_count", 32'(tick_count), 32'(exp_ticks % 16));
    check("irq_tick_pulses", 32'(tick_pulses), 32'd1);
    check("irq_q_empty", 32'(exp_q.size()), 32'd0);

    // IRQ and START together: CLR wins, START follows
    push_wr(3'd0, 16'h0000);
    push_wr(3'd2, 16'h0100);
    push_wr(3'd3, 16'h0000);
    push_wr(3'd1, 16'h0007);
    exp_ticks++;
    irq_raise = 1'b1;
    step();
    irq_raise = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_period = 32'h0000_0100;
    cmd_continuous = 1'b1;
    check("both_cmd_ready_idle", 32'(cmd_ready), 32'd0);
    step();
    check("both_cmd_ready_clr", 32'(cmd_ready), 32'd0);
    send_cmd(2'd0, 32'h0000_0100, 1'b1, acc);
    wait_idle();
    check("both_tick_count", 32'(tick_count), 32'(exp_ticks % 16));
    check("both_q_empty", 32'(exp_q.size()), 32'd0);

    // Tick counter wrap at 2^TW
    for (int i = 0; i < 14; i++) service_irq();
    step();
    check("wrap_tick_count", 32'(tick_count), 32'(exp_ticks % 16));
    check("wrap_is_zero", 32'(tick_count), 32'd0);
    check("wrap_tick_pulses", 32'(tick_pulses), 32'(exp_ticks));
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Reserved op: accepted, no bus activity
    send_cmd(2'd3, 32'h0, 1'b0, acc);
    repeat (2) step();
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in SNAP_RL releases the bus, then auto-start repeats
    push_wr(3'd4, 16'h0000);
    push_rd(3'd4);
    send_cmd(2'd2, 32'h0, 1'b0, acc);
    step();
    reset_n = 1'b0;
    step();
    check("midrst_cs", 32'(tmr_chipselect), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_snap_value", snap_value, 32'h0);
    check("midrst_q_empty", 32'(exp_q.size()), 32'd0);
    push_wr(3'd2, 16'h2E97);
    push_wr(3'd3, 16'h0002);
    push_wr(3'd1, 16'h0007);
    reset_n = 1'b1;
    repeat (4) step();
    check("reauto_busy", 32'(busy), 32'd0);
    check("reauto_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
